fifo_checker: RTL and testbench
===============================

FIFO_CHECKER -- requirements
Module: fifo_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the checked FIFO data path.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: depth of the checked FIFO; power of two, 4 to 256.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the error and correct counters.
REQ-004 SHALL have port clk, input, 1 bit: single clock shared with the checked FIFO; all sampling on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset; the same net as the FIFO reset.
REQ-006 SHALL have port chk_en, input, 1 bit: enables comparison and counting.
REQ-007 SHALL have port test_finished, input, 1 bit: end-of-test request.
REQ-008 SHALL have ports data_in (DATA_WIDTH), wr_en (1) and rd_en (1), inputs: copies of the FIFO stimulus.
REQ-009 SHALL have ports dut_data_out (DATA_WIDTH), dut_wr_ack, dut_overflow, dut_underflow, dut_full, dut_empty, dut_almostfull and dut_almostempty (1 each), inputs: FIFO responses.
REQ-010 SHALL have ports error_count and correct_count, outputs, CNT_WIDTH each: saturating compare tallies.
REQ-011 SHALL have port mismatch, output, 1 bit: one-cycle pulse on any failed compare.
REQ-012 SHALL have port mismatch_vec, output, 8 bits: per-field fail flags of the last compare, in the order {data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty} (MSB to LSB).
REQ-013 SHALL have port done, output, 1 bit: high in state DONE.

Function
REQ-014 SHALL hold a shadow model made of a FIFO_DEPTH x DATA_WIDTH memory, a write pointer, a read pointer and a count of width $clog2(FIFO_DEPTH)+1.
REQ-015 SHALL update the shadow model every edge in states CHECK and IDLE, independent of chk_en.
REQ-016 SHALL perform a write, storing data_in at the write pointer and incrementing it, when wr_en=1 and the shadow count < FIFO_DEPTH.
REQ-017 SHALL perform a read, incrementing the read pointer, when rd_en=1 and the shadow count > 0.
REQ-018 SHALL wrap both pointers modulo FIFO_DEPTH.
REQ-019 SHALL handle wr_en=rd_en=1 by count: at count 0 only the write occurs; at count FIFO_DEPTH only the read occurs; otherwise both occur and the count is unchanged.
REQ-020 SHALL register the expected sequential outputs at each edge: exp_wr_ack = write performed; exp_overflow = wr_en and count == FIFO_DEPTH; exp_underflow = rd_en and count == 0; exp_data_out = memory at the read pointer when a read is performed, otherwise unchanged.
REQ-021 SHALL derive the expected flags combinationally from the post-update count: full = (count == FIFO_DEPTH); empty = (count == 0); almostfull = (count == FIFO_DEPTH-1); almostempty = (count == 1).
REQ-022 SHALL compare with one cycle of latency: at edge N+1, compare the expected values produced by edge N against the dut_* values sampled at edge N+1.
REQ-023 SHALL suppress the comparison at the first edge after reset release, using an internal valid bit.
REQ-024 SHALL, on each enabled compare (chk_en=1, valid=1, state CHECK), increment error_count by 1 if any field differs, otherwise increment correct_count by 1.
REQ-025 SHALL saturate both counters at 2^CNT_WIDTH-1.
REQ-026 SHALL, on each enabled compare, assert mismatch for exactly the cycle following a failing compare and update mismatch_vec.
REQ-027 SHALL leave mismatch_vec unchanged on cycles with no enabled compare.
REQ-028 SHALL implement the FSM IDLE -> CHECK when chk_en=1; CHECK -> IDLE when chk_en=0; IDLE or CHECK -> DONE when test_finished=1; DONE is absorbing until reset.
REQ-029 SHALL, in DONE, freeze the counters and mismatch_vec, hold mismatch at 0 and stop shadow updates.
REQ-030 SHALL give test_finished priority over chk_en in the same cycle; the compare on the edge that enters DONE is still counted.

Reset
REQ-031 SHALL, on rst_n=0, immediately clear the pointers, shadow count, valid bit, exp_* registers, error_count, correct_count, mismatch, mismatch_vec and done, and enter IDLE.
REQ-032 SHALL leave the shadow memory contents uninitialised after reset; they are never compared before being written.
REQ-033 SHALL treat a reset asserted mid-test the same as a power-on reset, discarding all in-flight expected values.

Verification
REQ-034 Reset then chk_en=1, 8 writes of 0x0001..0x0008 with a matching FIFO -> correct_count=8 after the 9th edge, error_count=0, expected full=1 on the last write.
REQ-035 From full: wr_en=1 with a matching FIFO asserting overflow -> correct_count +1; FIFO withholding overflow -> error_count=1, mismatch_vec=8'b0010_0000, mismatch pulses 1 cycle.
REQ-036 From empty: wr_en=rd_en=1 with data 0xABCD -> expected wr_ack=1, underflow=1, count=1, almostempty=1; a read next cycle gives expected data_out=0xABCD.
REQ-037 Force dut_data_out to 0xFFFF on one read -> error_count=1, mismatch_vec[7]=1; the next cycle is correct and clears mismatch_vec to 0.
REQ-038 test_finished=1 with chk_en=1 -> done=1 from the next edge, and the counters hold through 20 further random cycles.
REQ-039 With CNT_WIDTH=4, force 20 mismatches -> error_count saturates at 15.
REQ-040 rst_n pulsed low mid-stream -> all outputs 0 immediately and no compare on the first edge after release.

Source files
------------

// File: rtl/fifo_checker.sv
// fifo_checker: scoreboard for a synchronous FIFO. A shadow FIFO is driven
// by copies of the FIFO stimulus. The responses it predicts for edge N are
// compared with the FIFO outputs sampled at edge N+1. Pass and fail tallies
// saturate, and a per-field fail vector records the last enabled compare.
module fifo_checker #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  chk_en,
   input  logic                  test_finished,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] dut_data_out,
   input  logic                  dut_wr_ack,
   input  logic                  dut_overflow,
   input  logic                  dut_underflow,
   input  logic                  dut_full,
   input  logic                  dut_empty,
   input  logic                  dut_almostfull,
   input  logic                  dut_almostempty,
   output logic [CNT_WIDTH-1:0]  error_count,
   output logic [CNT_WIDTH-1:0]  correct_count,
   output logic                  mismatch,
   output logic [7:0]            mismatch_vec,
   output logic                  done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   localparam logic [OCC_W-1:0]     OCC_ZERO  = {OCC_W{1'b0}};
   localparam logic [OCC_W-1:0]     OCC_ONE   = OCC_W'(1);
   localparam logic [OCC_W-1:0]     OCC_FULL  = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0]     OCC_AFULL = OCC_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] TALLY_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TALLY_MAX = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e state_q, state_d;

   // Shadow FIFO
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  valid_q, valid_d;

   // Expected sequential responses, produced one edge ahead of the compare
   logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
   logic                  exp_wr_ack_q, exp_wr_ack_d;
   logic                  exp_ovf_q, exp_ovf_d;
   logic                  exp_udf_q, exp_udf_d;

   // Expected status flags, decoded from the post-update occupancy
   logic                  exp_full_s, exp_empty_s, exp_afull_s, exp_aempty_s;

   logic                  shadow_upd_s;
   logic                  wr_do_s, rd_do_s;
   logic                  cmp_en_s;
   logic [7:0]            fail_vec_s;
   logic                  fail_s;

   logic [CNT_WIDTH-1:0]  err_q, err_d;
   logic [CNT_WIDTH-1:0]  cor_q, cor_d;
   logic                  mis_q, mis_d;
   logic [7:0]            vec_q, vec_d;
   logic                  done_q, done_d;

   // Next-state logic: test_finished wins over chk_en, and DONE is held until reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (test_finished) begin
               state_d = ST_DONE;
            end else if (chk_en) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (test_finished) begin
               state_d = ST_DONE;
            end else if (!chk_en) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Shadow FIFO update and expected response prediction (frozen once done)
   always_comb begin
      shadow_upd_s = (state_q == ST_IDLE) || (state_q == ST_CHECK);
      wr_do_s      = shadow_upd_s && wr_en && (occ_q < OCC_FULL);
      rd_do_s      = shadow_upd_s && rd_en && (occ_q != OCC_ZERO);

      wptr_d       = wr_do_s ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d       = rd_do_s ? (rptr_q + PTR_ONE) : rptr_q;

      occ_d        = occ_q;
      case ({wr_do_s, rd_do_s})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase

      exp_wr_ack_d = exp_wr_ack_q;
      exp_ovf_d    = exp_ovf_q;
      exp_udf_d    = exp_udf_q;
      exp_data_d   = exp_data_q;
      if (shadow_upd_s) begin
         exp_wr_ack_d = wr_do_s;
         exp_ovf_d    = wr_en && (occ_q == OCC_FULL);
         exp_udf_d    = rd_en && (occ_q == OCC_ZERO);
         exp_data_d   = rd_do_s ? mem_q[rptr_q] : exp_data_q;
      end else begin
         exp_wr_ack_d = exp_wr_ack_q;
         exp_ovf_d    = exp_ovf_q;
         exp_udf_d    = exp_udf_q;
         exp_data_d   = exp_data_q;
      end
   end

   // Flags expected from the FIFO reflect the occupancy after the last edge
   always_comb begin
      exp_full_s   = (occ_q == OCC_FULL);
      exp_empty_s  = (occ_q == OCC_ZERO);
      exp_afull_s  = (occ_q == OCC_AFULL);
      exp_aempty_s = (occ_q == OCC_ONE);
   end

   // Compare the FIFO outputs with the predictions and update the tallies
   always_comb begin
      cmp_en_s   = (state_q == ST_CHECK) && chk_en && valid_q;
      fail_vec_s = {(dut_data_out    != exp_data_q),
                    (dut_wr_ack      != exp_wr_ack_q),
                    (dut_overflow    != exp_ovf_q),
                    (dut_underflow   != exp_udf_q),
                    (dut_full        != exp_full_s),
                    (dut_empty       != exp_empty_s),
                    (dut_almostfull  != exp_afull_s),
                    (dut_almostempty != exp_aempty_s)};
      fail_s     = |fail_vec_s;

      err_d      = err_q;
      cor_d      = cor_q;
      mis_d      = 1'b0;
      vec_d      = vec_q;
      if (cmp_en_s) begin
         vec_d = fail_vec_s;
         mis_d = fail_s;
         if (fail_s) begin
            err_d = (err_q == TALLY_MAX) ? err_q : (err_q + TALLY_ONE);
            cor_d = cor_q;
         end else begin
            err_d = err_q;
            cor_d = (cor_q == TALLY_MAX) ? cor_q : (cor_q + TALLY_ONE);
         end
      end else begin
         err_d = err_q;
         cor_d = cor_q;
         mis_d = 1'b0;
         vec_d = vec_q;
      end

      // The first edge after reset has no prediction behind it
      valid_d    = 1'b1;
      done_d     = (state_d == ST_DONE);
   end

   // Shadow storage is not reset: a location is always written before it is read
   always_ff @(posedge clk) begin
      if (wr_do_s) begin
         mem_q[wptr_q] <= data_in;
      end
   end

   // State, shadow pointers, predictions and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wptr_q       <= {PTR_W{1'b0}};
         rptr_q       <= {PTR_W{1'b0}};
         occ_q        <= OCC_ZERO;
         valid_q      <= 1'b0;
         exp_data_q   <= {DATA_WIDTH{1'b0}};
         exp_wr_ack_q <= 1'b0;
         exp_ovf_q    <= 1'b0;
         exp_udf_q    <= 1'b0;
         err_q        <= {CNT_WIDTH{1'b0}};
         cor_q        <= {CNT_WIDTH{1'b0}};
         mis_q        <= 1'b0;
         vec_q        <= 8'h00;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         occ_q        <= occ_d;
         valid_q      <= valid_d;
         exp_data_q   <= exp_data_d;
         exp_wr_ack_q <= exp_wr_ack_d;
         exp_ovf_q    <= exp_ovf_d;
         exp_udf_q    <= exp_udf_d;
         err_q        <= err_d;
         cor_q        <= cor_d;
         mis_q        <= mis_d;
         vec_q        <= vec_d;
         done_q       <= done_d;
      end
   end

   assign error_count   = err_q;
   assign correct_count = cor_q;
   assign mismatch      = mis_q;
   assign mismatch_vec  = vec_q;
   assign done          = done_q;

endmodule

// File: tb/tb_fifo_checker.sv
// tb_fifo_checker: drives fifo_checker with FIFO stimulus and with FIFO
// responses from a queue-based FIFO model. Selected response fields are
// corrupted on purpose. The expected tallies, mismatch pulse, fail vector
// and done flag are derived from the injected corruptions. Two instances
// share all stimulus; the second uses 4-bit tallies to exercise saturation.
module tb_fifo_checker;

   localparam int DW    = 16;
   localparam int DEPTH = 8;

   logic          clk;
   logic          rst_n;
   logic          chk_en;
   logic          test_finished;
   logic [DW-1:0] data_in;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] dut_data_out;
   logic          dut_wr_ack, dut_overflow, dut_underflow;
   logic          dut_full, dut_empty, dut_almostfull, dut_almostempty;

   logic [15:0]   err_a, cor_a;
   logic          mis_a, done_a;
   logic [7:0]    vec_a;
   logic [3:0]    err_b, cor_b;
   logic          mis_b, done_b;
   logic [7:0]    vec_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] r_data;
   logic          r_ack, r_ovf, r_udf;
   int            m_err, m_cor;
   logic          m_mis;
   logic [7:0]    m_vec;
   int            m_state;   // 0 idle, 1 checking, 2 finished
   bit            m_valid;

   fifo_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .test_finished(test_finished),
      .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .dut_data_out(dut_data_out), .dut_wr_ack(dut_wr_ack),
      .dut_overflow(dut_overflow), .dut_underflow(dut_underflow),
      .dut_full(dut_full), .dut_empty(dut_empty),
      .dut_almostfull(dut_almostfull), .dut_almostempty(dut_almostempty),
      .error_count(err_a), .correct_count(cor_a), .mismatch(mis_a),
      .mismatch_vec(vec_a), .done(done_a)
   );

   fifo_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .test_finished(test_finished),
      .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .dut_data_out(dut_data_out), .dut_wr_ack(dut_wr_ack),
      .dut_overflow(dut_overflow), .dut_underflow(dut_underflow),
      .dut_full(dut_full), .dut_empty(dut_empty),
      .dut_almostfull(dut_almostfull), .dut_almostempty(dut_almostempty),
      .error_count(err_b), .correct_count(cor_b), .mismatch(mis_b),
      .mismatch_vec(vec_b), .done(done_b)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic check_outputs(input string tag);
      check_val({tag, "_err16"}, 32'(err_a), 32'(sat(m_err, 65535)));
      check_val({tag, "_cor16"}, 32'(cor_a), 32'(sat(m_cor, 65535)));
      check_val({tag, "_err4"},  32'(err_b), 32'(sat(m_err, 15)));
      check_val({tag, "_cor4"},  32'(cor_b), 32'(sat(m_cor, 15)));
      check_val({tag, "_mis"},   32'(mis_a), 32'(m_mis));
      check_val({tag, "_mis4"},  32'(mis_b), 32'(m_mis));
      check_val({tag, "_vec"},   32'(vec_a), 32'(m_vec));
      check_val({tag, "_vec4"},  32'(vec_b), 32'(m_vec));
      check_val({tag, "_done"},  32'(done_a), 32'(m_state == 2));
      check_val({tag, "_done4"}, 32'(done_b), 32'(m_state == 2));
   endtask

   task automatic model_reset();
      q.delete();
      r_data  = '0;
      r_ack   = 1'b0;
      r_ovf   = 1'b0;
      r_udf   = 1'b0;
      m_err   = 0;
      m_cor   = 0;
      m_mis   = 1'b0;
      m_vec   = 8'h00;
      m_state = 0;
      m_valid = 1'b0;
   endtask

   // Assert reset between edges, check the outputs clear at once, release on a falling edge
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: present stimulus plus (optionally corrupted) FIFO responses, then check
   task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d,
                       input logic en, input logic fin, input logic [7:0] cm);
      int sz;
      bit wdo, rdo;
      wr_en           = wr;
      rd_en           = rd;
      data_in         = d;
      chk_en          = en;
      test_finished   = fin;
      sz              = q.size();
      dut_data_out    = r_data ^ (cm[7] ? 16'hFFFF : 16'h0000);
      dut_wr_ack      = r_ack ^ cm[6];
      dut_overflow    = r_ovf ^ cm[5];
      dut_underflow   = r_udf ^ cm[4];
      dut_full        = (sz == DEPTH) ^ cm[3];
      dut_empty       = (sz == 0) ^ cm[2];
      dut_almostfull  = (sz == DEPTH - 1) ^ cm[1];
      dut_almostempty = (sz == 1) ^ cm[0];
      @(posedge clk);
      #1;
      if (m_state == 1 && en && m_valid) begin
         if (cm != 8'h00) begin
            m_err++;
            m_mis = 1'b1;
         end else begin
            m_cor++;
            m_mis = 1'b0;
         end
         m_vec = cm;
      end else begin
         m_mis = 1'b0;
      end
      m_valid = 1'b1;
      if (m_state != 2) begin
         wdo   = wr && (sz < DEPTH);
         rdo   = rd && (sz > 0);
         r_ack = wdo;
         r_ovf = wr && (sz == DEPTH);
         r_udf = rd && (sz == 0);
         if (rdo) r_data = q.pop_front();
         if (wdo) q.push_back(d);
         if (fin) m_state = 2;
         else if (en) m_state = 1;
         else m_state = 0;
      end
      check_outputs("cyc");
   endtask

   initial begin
      logic [7:0] cm;
      logic       en;
      rst_n = 1'b0; chk_en = 1'b0; test_finished = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      dut_data_out = '0; dut_wr_ack = 1'b0; dut_overflow = 1'b0; dut_underflow = 1'b0;
      dut_full = 1'b0; dut_empty = 1'b1; dut_almostfull = 1'b0; dut_almostempty = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Fill with 1..8 under a matching FIFO
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(i + 1), 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
      check_val("fill_cor", 32'(cor_a), 32'd8);
      check_val("fill_err", 32'(err_a), 32'd0);

      // Overflow: honoured, then withheld
      step(1'b1, 1'b0, 16'h0009, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 16'h000A, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h20);
      check_val("ovf_err", 32'(err_a), 32'd1);
      check_val("ovf_vec", 32'(vec_a), 32'h20);
      check_val("ovf_mis", 32'(mis_a), 32'd1);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
      check_val("ovf_mis_off", 32'(mis_a), 32'd0);
      check_val("ovf_cor", 32'(cor_a), 32'd11);

      // Drain past empty, then simultaneous read/write on empty
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
      check_val("rdwr_empty_err", 32'(err_a), 32'd1);

      // Corrupted read data, then a clean compare
      step(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h80);
      check_val("data_err", 32'(err_a), 32'd2);
      check_val("data_vec", 32'(vec_a), 32'h80);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
      check_val("data_vec_clr", 32'(vec_a), 32'h00);

      // Random traffic with occasional corruption, chk_en drops and one mid-stream reset
      for (int i = 0; i < 300; i++) begin
         en = ($urandom_range(0, 9) != 0);
         cm = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
              16'($urandom), en, 1'b0, cm);
         if (i == 150) do_reset();
      end

      // Saturation of the 4-bit tallies
      do_reset();
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 20; i++)
         step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 16'($urandom),
              1'b1, 1'b0, 8'h01);
      check_val("sat_err4", 32'(err_b), 32'd15);
      check_val("sat_err16", 32'(err_a), 32'd20);

      // End of test takes priority over chk_en; tallies then freeze
      step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h00);
      check_val("done_set", 32'(done_a), 32'd1);
      for (int i = 0; i < 20; i++) begin
         cm = 8'($urandom);
         step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 16'($urandom),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), cm);
      end
      check_val("done_err_hold", 32'(err_a), 32'd20);
      check_val("done_cor_hold", 32'(cor_a), 32'd1);
      check_val("done_mis_low", 32'(mis_a), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
